// File: rtl/tmds_encoder.sv
// Three-stage TMDS channel encoder: video (DVI 1.0 8b/10b with running disparity),
// control, guard band and data island. Define TMDS_TERC4_EN to build the TERC4 table.
module tmds_encoder #(
  parameter int CHANNEL = 0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ce,
  input  logic [1:0] i_mode,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctl,
  input  logic [3:0] i_aux,
  output logic [9:0] o_word,
  output logic [4:0] o_disp
);

  typedef enum logic [1:0] {
    MODE_CTL    = 2'd0,
    MODE_VIDEO  = 2'd1,
    MODE_GUARD  = 2'd2,
    MODE_ISLAND = 2'd3
  } mode_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [9:0] ctl_code(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4_code(input logic [3:0] a);
    case (a)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000110;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction
`endif

  function automatic logic [9:0] brev10(input logic [9:0] v);
    logic [9:0] r;
    for (int unsigned i = 0; i < 10; i++) r[i] = v[9 - i];
    return r;
  endfunction

  // Stage 1
  mode_e       r1_mode;
  logic [7:0]  r1_data;
  logic [1:0]  r1_ctl;
  logic [3:0]  r1_aux;
  logic [3:0]  r1_n1;
  // Stage 2
  mode_e       r2_mode;
  logic [1:0]  r2_ctl;
  logic [3:0]  r2_aux;
  logic [8:0]  r2_qm;
  logic [3:0]  r2_n1;
  // Stage 3
  logic [9:0]        r_word;
  logic signed [4:0] r_cnt;

  logic [8:0]        w_qm;
  logic [3:0]        w_qm_n1;
  logic [9:0]        w_qout;
  logic signed [4:0] w_cnt_next;
  logic signed [4:0] w_n1;
  logic signed [4:0] w_diff;
  logic              w_q8;

  always_comb begin
    logic use_xnor;
    logic [8:0] qm;
    use_xnor = (r1_n1 > 4'd4) || ((r1_n1 == 4'd4) && !r1_data[0]);
    qm       = '0;
    qm[0]    = r1_data[0];
    for (int unsigned i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ r1_data[i]) : (qm[i-1] ^ r1_data[i]);
    qm[8]    = ~use_xnor;
    w_qm     = qm;
    w_qm_n1  = popcount8(qm[7:0]);
  end

  // N1 - N0 of q_m[7:0]; N0 = 8 - N1, so the difference is 2*N1 - 8.
  assign w_n1   = $signed({1'b0, r2_n1});
  assign w_diff = w_n1 - (5'sd8 - w_n1);
  assign w_q8   = r2_qm[8];

  always_comb begin
    w_qout     = ctl_code(r2_ctl);
    w_cnt_next = '0;
    case (r2_mode)
      MODE_VIDEO: begin
        if ((r_cnt == 0) || (w_diff == 0)) begin
          w_qout     = {~w_q8, w_q8, w_q8 ? r2_qm[7:0] : ~r2_qm[7:0]};
          w_cnt_next = w_q8 ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if (((r_cnt > 0) && (w_diff > 0)) || ((r_cnt < 0) && (w_diff < 0))) begin
          w_qout     = {1'b1, w_q8, ~r2_qm[7:0]};
          w_cnt_next = r_cnt + (w_q8 ? 5'sd2 : 5'sd0) - w_diff;
        end else begin
          w_qout     = {1'b0, w_q8, r2_qm[7:0]};
          w_cnt_next = r_cnt - (w_q8 ? 5'sd0 : 5'sd2) + w_diff;
        end
      end
      MODE_GUARD:  w_qout = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;
`ifdef TMDS_TERC4_EN
      MODE_ISLAND: w_qout = terc4_code(r2_aux);
`else
      MODE_ISLAND: w_qout = ctl_code(r2_ctl);
`endif
      default:     w_qout = ctl_code(r2_ctl);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r1_mode <= MODE_CTL;
      r1_data <= '0;
      r1_ctl  <= '0;
      r1_aux  <= '0;
      r1_n1   <= '0;
      r2_mode <= MODE_CTL;
      r2_ctl  <= '0;
      r2_aux  <= '0;
      r2_qm   <= '0;
      r2_n1   <= '0;
      r_word  <= 10'b0010101011;
      r_cnt   <= '0;
    end else if (i_ce) begin
      r1_mode <= mode_e'(i_mode);
      r1_data <= i_data;
      r1_ctl  <= i_ctl;
      r1_aux  <= i_aux;
      r1_n1   <= popcount8(i_data);
      r2_mode <= r1_mode;
      r2_ctl  <= r1_ctl;
      r2_aux  <= r1_aux;
      r2_qm   <= w_qm;
      r2_n1   <= w_qm_n1;
      r_word  <= brev10(w_qout);
      r_cnt   <= w_cnt_next;
    end
  end

  assign o_word = r_word;
  assign o_disp = r_cnt;

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder against a prefix-parity TMDS model and an
// independent decoder; covers reset, all modes, i_ce stalls and mid-stream reset.
module tb_tmds_encoder;

  logic       clk = 1'b0;
  logic       i_reset, i_ce;
  logic [1:0] i_mode, i_ctl;
  logic [7:0] i_data;
  logic [3:0] i_aux;
  logic [9:0] o_word, o_word1;
  logic [4:0] o_disp, o_disp1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tmds_encoder #(.CHANNEL(0)) u_dut0 (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_mode(i_mode), .i_data(i_data),
    .i_ctl(i_ctl), .i_aux(i_aux), .o_word(o_word), .o_disp(o_disp));

  tmds_encoder #(.CHANNEL(1)) u_dut1 (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_mode(i_mode), .i_data(i_data),
    .i_ctl(i_ctl), .i_aux(i_aux), .o_word(o_word1), .o_disp(o_disp1));

  typedef struct packed {
    logic [9:0] w;
    logic [4:0] d;
    logic       vid;
    logic [7:0] data;
  } ent_t;

  ent_t m1, m2, m3;
  int   m_cnt;

  logic [9:0] TERC4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  function automatic logic [9:0] brev(input logic [9:0] x);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = x[9 - i];
    return r;
  endfunction

  function automatic logic [9:0] ctl_q(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  // q_m[i] is the prefix parity of D[0..i]; the XNOR variant flips odd positions.
  function automatic void ref_video(input logic [7:0] d, input int cnt_in,
                                    output logic [9:0] q, output int cnt_out);
    int n1, n1q, n0q;
    bit xn, par;
    logic [8:0] qm;
    n1  = $countones(d);
    xn  = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    par = 1'b0;
    for (int i = 0; i < 8; i++) begin
      par   = par ^ d[i];
      qm[i] = (xn && (i % 2 == 1)) ? ~par : par;
    end
    qm[8] = !xn;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (cnt_in == 0 || n1q == n0q) begin
      q       = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_out = cnt_in + (qm[8] ? (n1q - n0q) : (n0q - n1q));
    end else if ((cnt_in > 0 && n1q > n0q) || (cnt_in < 0 && n0q > n1q)) begin
      q       = {1'b1, qm[8], ~qm[7:0]};
      cnt_out = cnt_in + 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q       = {1'b0, qm[8], qm[7:0]};
      cnt_out = cnt_in - 2 * (1 - int'(qm[8])) + n1q - n0q;
    end
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] q);
    logic [7:0] low, d;
    low  = q[9] ? ~q[7:0] : q[7:0];
    d[0] = low[0];
    for (int i = 1; i < 8; i++) d[i] = q[8] ? (low[i] ^ low[i-1]) : ~(low[i] ^ low[i-1]);
    return d;
  endfunction

  function automatic ent_t rst_ent();
    ent_t e;
    e.w = 10'h0AB; e.d = '0; e.vid = 1'b0; e.data = '0;
    return e;
  endfunction

  task automatic drive(input logic [1:0] mode, input logic [7:0] data, input logic [1:0] ctl,
                       input logic [3:0] aux, input logic ce, input logic rst);
    ent_t e;
    logic [9:0] q;
    int nc;
    i_mode = mode; i_data = data; i_ctl = ctl; i_aux = aux; i_ce = ce; i_reset = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      m1 = rst_ent(); m2 = m1; m3 = m1; m_cnt = 0;
    end else if (ce) begin
      nc = 0; e.vid = 1'b0; e.data = data;
      case (mode)
        2'd1: begin ref_video(data, m_cnt, q, nc); e.vid = 1'b1; end
        2'd2: q = 10'b1011001100;
`ifdef TMDS_TERC4_EN
        2'd3: q = TERC4[aux];
`else
        2'd3: q = ctl_q(ctl);
`endif
        default: q = ctl_q(ctl);
      endcase
      m_cnt = nc; e.w = brev(q); e.d = nc[4:0];
      m3 = m2; m2 = m1; m1 = e;
    end
  endtask

  task automatic test_reset();
    drive(2'd1, 8'hA5, 2'd0, 4'd0, 1'b0, 1'b1);
    drive(2'd1, 8'h3C, 2'd0, 4'd0, 1'b1, 1'b1);
    total++; if (o_word !== 10'h0AB) $display("FAIL reset_word got %h want %h", o_word, 10'h0AB); else passed++;
    total++; if (o_disp !== 5'd0) $display("FAIL reset_disp got %0d want 0", $signed(o_disp)); else passed++;
    for (int k = 0; k < 5; k++) begin
      drive(2'd0, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
      total++; if (o_word !== 10'h0AB) $display("FAIL idle_word got %h want %h", o_word, 10'h0AB); else passed++;
      total++; if (o_disp !== 5'd0) $display("FAIL idle_disp got %0d want 0", $signed(o_disp)); else passed++;
    end
  endtask

  task automatic test_video_zero();
    drive(2'd1, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
    drive(2'd1, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
    total++; if (o_word !== 10'h0AB) $display("FAIL vz_latency got %h want %h", o_word, 10'h0AB); else passed++;
    drive(2'd0, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
    total++; if (o_word !== 10'h002) $display("FAIL vz_word0 got %h want %h", o_word, 10'h002); else passed++;
    total++; if (o_disp !== 5'h18) $display("FAIL vz_disp0 got %0d want -8", $signed(o_disp)); else passed++;
    drive(2'd0, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
    total++; if (o_word !== 10'h3FF) $display("FAIL vz_word1 got %h want %h", o_word, 10'h3FF); else passed++;
    total++; if (o_disp !== 5'd2) $display("FAIL vz_disp1 got %0d want 2", $signed(o_disp)); else passed++;
    drive(2'd0, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
    total++; if (o_disp !== 5'd0) $display("FAIL vz_disp_clear got %0d want 0", $signed(o_disp)); else passed++;
  endtask

  task automatic test_control();
    logic [9:0] want [4] = '{10'h0AB, 10'h354, 10'h0AA, 10'h355};
    for (int c = 1; c < 4; c++) begin
      drive(2'd0, 8'h00, 2'(c), 4'd0, 1'b1, 1'b0);
      drive(2'd0, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
      drive(2'd0, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
      total++; if (o_word !== want[c]) $display("FAIL ctl%0d_word got %h want %h", c, o_word, want[c]); else passed++;
    end
    drive(2'd1, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
    drive(2'd0, 8'h00, 2'd3, 4'd0, 1'b1, 1'b0);
    drive(2'd1, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
    drive(2'd0, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
    total++; if (o_word !== 10'h355) $display("FAIL ctl_blank_word got %h want %h", o_word, 10'h355); else passed++;
    total++; if (o_disp !== 5'd0) $display("FAIL ctl_blank_disp got %0d want 0", $signed(o_disp)); else passed++;
    drive(2'd0, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
    total++; if (o_word !== 10'h002) $display("FAIL ctl_restart_word got %h want %h", o_word, 10'h002); else passed++;
    total++; if (o_disp !== 5'h18) $display("FAIL ctl_restart_disp got %0d want -8", $signed(o_disp)); else passed++;
    drive(2'd0, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic test_guard();
    drive(2'd2, 8'h5A, 2'd1, 4'd0, 1'b1, 1'b0);
    drive(2'd0, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
    drive(2'd0, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
    total++; if (o_word !== 10'h0CD) $display("FAIL guard_ch0 got %h want %h", o_word, 10'h0CD); else passed++;
    total++; if (o_word1 !== 10'h332) $display("FAIL guard_ch1 got %h want %h", o_word1, 10'h332); else passed++;
    total++; if (o_disp1 !== 5'd0) $display("FAIL guard_disp got %0d want 0", $signed(o_disp1)); else passed++;
  endtask

  task automatic test_island();
    logic [9:0] want0;
`ifdef TMDS_TERC4_EN
    want0 = 10'h0E5;
`else
    want0 = 10'h0AA;
`endif
    for (int a = 0; a < 16; a++) begin
      drive(2'd3, 8'(a * 17), 2'(a) ^ 2'b10, 4'(a), 1'b1, 1'b0);
      total++; if (o_word !== m3.w) $display("FAIL island_word a=%0d got %h want %h", a, o_word, m3.w); else passed++;
      if (a == 2) begin
        total++; if (o_word !== want0) $display("FAIL island_aux0 got %h want %h", o_word, want0); else passed++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive(2'd0, 8'h00, 2'd0, 4'd0, 1'b1, 1'b0);
      total++; if (o_word !== m3.w) $display("FAIL island_tail got %h want %h", o_word, m3.w); else passed++;
    end
  endtask

  task automatic test_random(input int n, input bit stall);
    logic [1:0] mode;
    logic       ce;
    int         dsp;
    for (int k = 0; k < n; k++) begin
      mode = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
      ce   = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      drive(mode, 8'($urandom), 2'($urandom), 4'($urandom), ce, 1'b0);
      dsp = $signed(o_disp);
      total++; if (o_word !== m3.w) $display("FAIL rnd_word k=%0d got %h want %h", k, o_word, m3.w); else passed++;
      total++; if (o_disp !== m3.d) $display("FAIL rnd_disp k=%0d got %0d want %0d", k, dsp, $signed(m3.d)); else passed++;
      total++; if (dsp > 10 || dsp < -10) $display("FAIL rnd_bound k=%0d got %0d want |d|<=10", k, dsp); else passed++;
      if (m3.vid) begin
        total++;
        if (decode(brev(o_word)) !== m3.data)
          $display("FAIL rnd_decode k=%0d got %h want %h", k, decode(brev(o_word)), m3.data);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) drive(2'd1, 8'($urandom), 2'd0, 4'd0, 1'b1, 1'b0);
    drive(2'd1, 8'h81, 2'd0, 4'd0, 1'b1, 1'b1);
    total++; if (o_word !== 10'h0AB) $display("FAIL rstmid_word got %h want %h", o_word, 10'h0AB); else passed++;
    total++; if (o_disp !== 5'd0) $display("FAIL rstmid_disp got %0d want 0", $signed(o_disp)); else passed++;
    for (int k = 0; k < 2; k++) begin
      drive(2'd1, 8'($urandom), 2'd0, 4'd0, 1'b1, 1'b0);
      total++; if (o_word !== 10'h0AB) $display("FAIL rstmid_drop got %h want %h", o_word, 10'h0AB); else passed++;
    end
    drive(2'd1, 8'($urandom), 2'd0, 4'd0, 1'b1, 1'b0);
    total++; if (o_word !== m3.w) $display("FAIL rstmid_first got %h want %h", o_word, m3.w); else passed++;
    total++; if (o_disp !== m3.d) $display("FAIL rstmid_firstdisp got %0d want %0d", $signed(o_disp), $signed(m3.d)); else passed++;
  endtask

  initial begin
    i_reset = 1'b1; i_ce = 1'b0; i_mode = '0; i_data = '0; i_ctl = '0; i_aux = '0;
    m1 = rst_ent(); m2 = m1; m3 = m1; m_cnt = 0;
    test_reset();
    test_video_zero();
    test_control();
    test_guard();
    test_island();
    test_random(10000, 1'b0);
    test_random(2000, 1'b1);
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
